// File: rtl/mispredict_recovery.sv
// Branch mispredict recovery sequencer: flush pulse, youngest-first ROB walk, tail rewind, fetch redirect.
// Optional RECOVERY_STATS_EN adds mispredict and walk-cycle counters; otherwise those outputs are tied to 0.
module mispredict_recovery #(
    parameter int  ROB_DEPTH = 16,
    parameter int  XLEN      = 32,
    localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mispredict_i,
    input  logic [XLEN-1:0]  target_pc_i,
    input  logic [ROB_W-1:0] recover_tag_i,
    input  logic [ROB_W-1:0] rob_head_i,
    input  logic [ROB_W-1:0] rob_tail_i,
    output logic             flush_o,
    output logic             busy_o,
    output logic             walk_valid_o,
    output logic [ROB_W-1:0] walk_tag_o,
    output logic             rob_tail_we_o,
    output logic [ROB_W-1:0] rob_tail_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      mp_count_o,
    output logic [31:0]      walk_cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_WALK,
        S_REDIRECT
    } state_t;

    state_t            state_reg;
    logic [ROB_W-1:0]  tag_reg;
    logic [ROB_W-1:0]  tail_reg;
    logic [XLEN-1:0]   target_reg;

    logic [ROB_W-1:0]  age_new;
    logic [ROB_W-1:0]  age_cap;
    logic              take_new;
    logic [ROB_W-1:0]  eff_tag;
    logic [XLEN-1:0]   eff_target;
    logic [ROB_W-1:0]  walk_count;

    // A mispredict arriving during FLUSH came from a branch issued before the
    // flush; it wins only if it is strictly older (closer to head).
    assign age_new    = recover_tag_i - rob_head_i;
    assign age_cap    = tag_reg - rob_head_i;
    assign take_new   = (state_reg == S_FLUSH) && mispredict_i && (age_new < age_cap);
    assign eff_tag    = take_new ? recover_tag_i : tag_reg;
    assign eff_target = take_new ? target_pc_i : target_reg;
    assign walk_count = tail_reg - eff_tag - ROB_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            tag_reg          <= '0;
            tail_reg         <= '0;
            target_reg       <= '0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            walk_valid_o     <= 1'b0;
            walk_tag_o       <= '0;
            rob_tail_we_o    <= 1'b0;
            rob_tail_o       <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            flush_o       <= 1'b0;
            rob_tail_we_o <= 1'b0;
            rob_tail_o    <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (mispredict_i) begin
                        tag_reg    <= recover_tag_i;
                        target_reg <= target_pc_i;
                        tail_reg   <= rob_tail_i;
                        flush_o    <= 1'b1;
                        busy_o     <= 1'b1;
                        state_reg  <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    tag_reg    <= eff_tag;
                    target_reg <= eff_target;
                    if (walk_count == '0) begin
                        state_reg        <= S_REDIRECT;
                        rob_tail_we_o    <= 1'b1;
                        rob_tail_o       <= eff_tag + ROB_W'(1);
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= eff_target;
                    end else begin
                        state_reg    <= S_WALK;
                        walk_valid_o <= 1'b1;
                        walk_tag_o   <= tail_reg - ROB_W'(1);
                    end
                end
                S_WALK: begin
                    // Walk ends once the entry just above the branch has been rolled back.
                    if (walk_tag_o == tag_reg + ROB_W'(1)) begin
                        state_reg        <= S_REDIRECT;
                        walk_valid_o     <= 1'b0;
                        walk_tag_o       <= '0;
                        rob_tail_we_o    <= 1'b1;
                        rob_tail_o       <= tag_reg + ROB_W'(1);
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= target_reg;
                    end else begin
                        walk_tag_o <= walk_tag_o - ROB_W'(1);
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_reg        <= S_IDLE;
                        redirect_valid_o <= 1'b0;
                        redirect_pc_o    <= '0;
                        busy_o           <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef RECOVERY_STATS_EN
    logic [31:0] mp_count_reg;
    logic [31:0] walk_cycles_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mp_count_reg    <= '0;
            walk_cycles_reg <= '0;
        end else begin
            if (state_reg == S_IDLE && mispredict_i) begin
                mp_count_reg <= mp_count_reg + 32'd1;
            end
            if (state_reg == S_WALK) begin
                walk_cycles_reg <= walk_cycles_reg + 32'd1;
            end
        end
    end

    assign mp_count_o    = mp_count_reg;
    assign walk_cycles_o = walk_cycles_reg;
`else
    assign mp_count_o    = 32'd0;
    assign walk_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_mispredict_recovery.sv
// Directed bench for mispredict_recovery: per-cycle timeline model of the recovery sequence plus literal pins.
module tb_mispredict_recovery;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mispredict_i = 1'b0;
    logic [31:0] target_pc_i = '0;
    logic [3:0]  recover_tag_i = '0;
    logic [3:0]  rob_head_i = '0;
    logic [3:0]  rob_tail_i = '0;
    logic        redirect_ready_i = 1'b0;
    logic        flush_o, busy_o, walk_valid_o, rob_tail_we_o, redirect_valid_o;
    logic [3:0]  walk_tag_o, rob_tail_o;
    logic [31:0] redirect_pc_o, mp_count_o, walk_cycles_o;

    mispredict_recovery #(.ROB_DEPTH(16), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mispredict_i     (mispredict_i),
        .target_pc_i      (target_pc_i),
        .recover_tag_i    (recover_tag_i),
        .rob_head_i       (rob_head_i),
        .rob_tail_i       (rob_tail_i),
        .flush_o          (flush_o),
        .busy_o           (busy_o),
        .walk_valid_o     (walk_valid_o),
        .walk_tag_o       (walk_tag_o),
        .rob_tail_we_o    (rob_tail_we_o),
        .rob_tail_o       (rob_tail_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .mp_count_o       (mp_count_o),
        .walk_cycles_o    (walk_cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic        busy;
        logic        wv;
        logic [3:0]  wt;
        logic        twe;
        logic [3:0]  tail;
        logic        rv;
        logic [31:0] pc;
    } obs_t;

    obs_t exp_mem [1024];
    obs_t act_mem [1024];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    int   mp_tot = 0;
    int   walk_tot = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: whole output bundle against the timeline the model wrote.
    always @(negedge clk) begin
        if (chk_en) begin
            obs_t a;
            a.flush = flush_o;
            a.busy  = busy_o;
            a.wv    = walk_valid_o;
            a.wt    = walk_tag_o;
            a.twe   = rob_tail_we_o;
            a.tail  = rob_tail_o;
            a.rv    = redirect_valid_o;
            a.pc    = redirect_pc_o;
            act_mem[cyc] = a;
            vectors++;
            if (a !== exp_mem[cyc]) begin
                miscompares++;
                $display("FAIL cyc%0d outputs: got flush=%0b busy=%0b wv=%0b wt=%0d twe=%0b tail=%0d rv=%0b pc=%h, required flush=%0b busy=%0b wv=%0b wt=%0d twe=%0b tail=%0d rv=%0b pc=%h",
                         cyc, a.flush, a.busy, a.wv, a.wt, a.twe, a.tail, a.rv, a.pc,
                         exp_mem[cyc].flush, exp_mem[cyc].busy, exp_mem[cyc].wv, exp_mem[cyc].wt,
                         exp_mem[cyc].twe, exp_mem[cyc].tail, exp_mem[cyc].rv, exp_mem[cyc].pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    function automatic int m16(input int x);
        return ((x % 16) + 16) % 16;
    endfunction

    // Writes the expected output timeline for one mispredict and drives the stimulus.
    // rst_off >= 0 asserts rst_n low for 3 cycles starting at cycle N+rst_off.
    task automatic run_case(input string nm, input int head, input int tail, input int tag,
                            input logic [31:0] tgt, input bit ovr, input int otag,
                            input logic [31:0] otgt, input bit mp_walk, input int hold,
                            input int rst_off, output int n);
        int          eff, cnt, r, lim, total;
        logic [31:0] eff_t;
        obs_t        o;
        step();
        n = cyc;
        eff   = tag;
        eff_t = tgt;
        if (ovr && m16(otag - head) < m16(tag - head)) begin
            eff   = otag;
            eff_t = otgt;
        end
        cnt = m16(tail - eff - 1);
        r   = n + 2 + cnt;
        lim = (rst_off >= 0) ? n + rst_off : n + 1000;

        o = '0; o.flush = 1'b1; o.busy = 1'b1;
        if (n + 1 <= lim) exp_mem[n + 1] = o;
        for (int i = 0; i < cnt; i++) begin
            o = '0; o.busy = 1'b1; o.wv = 1'b1; o.wt = 4'(m16(tail - 1 - i));
            if (n + 2 + i <= lim) exp_mem[n + 2 + i] = o;
        end
        for (int j = 0; j <= hold; j++) begin
            o = '0; o.busy = 1'b1; o.rv = 1'b1; o.pc = eff_t;
            if (j == 0) begin
                o.twe  = 1'b1;
                o.tail = 4'(m16(eff + 1));
            end
            if (r + j <= lim) exp_mem[r + j] = o;
        end

        total = (rst_off >= 0) ? rst_off + 6 : (r - n) + hold + 3;
        for (int c = 0; c < total; c++) begin
            if (c > 0) step();
            rob_head_i = 4'(head);
            rob_tail_i = 4'(tail);
            mispredict_i  = (c == 0) || (c == 1 && ovr) || (c == 2 && mp_walk);
            recover_tag_i = (c == 1 && ovr) ? 4'(otag) : ((c == 2 && mp_walk) ? 4'(head) : 4'(tag));
            target_pc_i   = (c == 1 && ovr) ? otgt : ((c == 2 && mp_walk) ? 32'hDEAD_0000 : tgt);
            redirect_ready_i = (rst_off < 0) && (n + c == r + hold);
            rst_n = !(rst_off >= 0 && c >= rst_off && c < rst_off + 3);
        end
        step();
        mispredict_i = 1'b0;
        redirect_ready_i = 1'b0;

        if (rst_off >= 0) begin
            mp_tot = 0;
            walk_tot = 0;
        end else begin
            mp_tot++;
            walk_tot += cnt;
        end
`ifdef RECOVERY_STATS_EN
        lit({nm, " mp_count"}, mp_count_o, 32'(mp_tot));
        lit({nm, " walk_cycles"}, walk_cycles_o, 32'(walk_tot));
`else
        lit({nm, " mp_count"}, mp_count_o, 32'd0);
        lit({nm, " walk_cycles"}, walk_cycles_o, 32'd0);
`endif
        $display("case %s: head=%0d tail=%0d tag=%0d eff_tag=%0d walk=%0d redirect=N+%0d pc=%h",
                 nm, head, tail, tag, eff, cnt, r - n, eff_t);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) begin
            exp_mem[i] = '0;
            act_mem[i] = '0;
        end
        rst_n = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        run_case("basic", 2, 7, 3, 32'h100, 1'b0, 0, 32'h0, 1'b0, 4, -1, n);
        lit("basic flush N+1", 32'(act_mem[n + 1].flush), 32'd1);
        lit("basic walk N+2", 32'(act_mem[n + 2].wt), 32'd6);
        lit("basic walk N+4", 32'(act_mem[n + 4].wt), 32'd4);
        lit("basic tail N+5", 32'(act_mem[n + 5].tail), 32'd4);
        lit("basic pc N+5", act_mem[n + 5].pc, 32'h100);
        lit("basic pc held N+9", act_mem[n + 9].pc, 32'h100);
        lit("basic busy N+10", 32'(act_mem[n + 10].busy), 32'd0);

        run_case("nowalk", 2, 7, 6, 32'h140, 1'b0, 0, 32'h0, 1'b0, 0, -1, n);
        lit("nowalk rv N+2", 32'(act_mem[n + 2].rv), 32'd1);
        lit("nowalk tail N+2", 32'(act_mem[n + 2].tail), 32'd7);

        run_case("wrap", 12, 2, 14, 32'h180, 1'b0, 0, 32'h0, 1'b1, 1, -1, n);
        lit("wrap walk N+2", 32'(act_mem[n + 2].wt), 32'd1);
        lit("wrap walk N+3", 32'(act_mem[n + 3].wt), 32'd0);
        lit("wrap walk N+4", 32'(act_mem[n + 4].wt), 32'd15);
        lit("wrap tail N+5", 32'(act_mem[n + 5].tail), 32'd15);

        run_case("override", 0, 12, 9, 32'h1C0, 1'b1, 4, 32'h200, 1'b0, 2, -1, n);
        lit("override last walk N+8", 32'(act_mem[n + 8].wt), 32'd5);
        lit("override pc N+9", act_mem[n + 9].pc, 32'h200);

        run_case("ignore", 0, 12, 9, 32'h300, 1'b1, 10, 32'h400, 1'b0, 0, -1, n);
        lit("ignore pc N+4", act_mem[n + 4].pc, 32'h300);
        lit("ignore tail N+4", 32'(act_mem[n + 4].tail), 32'd10);

        run_case("full", 5, 5, 5, 32'h440, 1'b0, 0, 32'h0, 1'b0, 0, -1, n);
        lit("full last walk N+16", 32'(act_mem[n + 16].wt), 32'd6);
        lit("full tail N+17", 32'(act_mem[n + 17].tail), 32'd6);

        run_case("reset_mid_walk", 2, 7, 3, 32'h500, 1'b0, 0, 32'h0, 1'b0, 0, 3, n);
        lit("reset walk N+3", 32'(act_mem[n + 3].wv), 32'd1);
        lit("reset busy N+4", 32'(act_mem[n + 4].busy), 32'd0);
        lit("reset no redirect N+8", 32'(act_mem[n + 8].rv), 32'd0);

        run_case("after_reset", 0, 3, 1, 32'h600, 1'b0, 0, 32'h0, 1'b0, 1, -1, n);
        lit("after_reset walk N+2", 32'(act_mem[n + 2].wt), 32'd2);
        lit("after_reset pc N+3", act_mem[n + 3].pc, 32'h600);

        step();
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
